// File: rtl/fpu_issue_scheduler.sv
// fpu_issue_scheduler: single-issue front end for the pipelined FPU cores
// (adder, multiplier, divider, ftoi, itof, sqrt). Registers the shared operand
// bus, tracks each in-flight op in a result-slot reservation vector, and
// captures the selected core output onto a single collision-free result bus.
// Optional build macro FPU_SCHED_FLUSH_EN adds a 'flush' input that kills
// every in-flight op.
module fpu_issue_scheduler #(
  parameter int TAG_W    = 5,
  parameter int LAT_ADD  = 4,
  parameter int LAT_MUL  = 3,
  parameter int LAT_DIV  = 12,
  parameter int LAT_FTOI = 2,
  parameter int LAT_ITOF = 2,
  parameter int LAT_SQRT = 12,
  parameter int MAX_LAT  = 12
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef FPU_SCHED_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  output logic [5:0]       fpu_add_operation,
  input  logic [31:0]      add_result,
  input  logic [31:0]      mul_result,
  input  logic [31:0]      div_result,
  input  logic [31:0]      ftoi_result,
  input  logic [31:0]      itof_result,
  input  logic [31:0]      sqrt_result,
  output logic             res_valid,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_err,
  output logic             busy
);

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; req_ready is combinational from req_op and the
  // reservation vector, and a stalled requester must hold its request.
  // Results have no backpressure: res_valid is a one-cycle strobe.

  localparam logic [2:0] U_ADD  = 3'd0;
  localparam logic [2:0] U_MUL  = 3'd1;
  localparam logic [2:0] U_DIV  = 3'd2;
  localparam logic [2:0] U_FTOI = 3'd3;
  localparam logic [2:0] U_ITOF = 3'd4;
  localparam logic [2:0] U_SQRT = 3'd5;
  localparam logic [2:0] U_NONE = 3'd6;

  function automatic int lat_of(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: lat_of = LAT_ADD;
      3'd2:       lat_of = LAT_MUL;
      3'd3:       lat_of = LAT_DIV;
      3'd4:       lat_of = LAT_FTOI;
      3'd5:       lat_of = LAT_ITOF;
      3'd6:       lat_of = LAT_SQRT;
      default:    lat_of = 1;
    endcase
  endfunction

  function automatic logic [2:0] unit_of(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: unit_of = U_ADD;
      3'd2:       unit_of = U_MUL;
      3'd3:       unit_of = U_DIV;
      3'd4:       unit_of = U_FTOI;
      3'd5:       unit_of = U_ITOF;
      3'd6:       unit_of = U_SQRT;
      default:    unit_of = U_NONE;
    endcase
  endfunction

  logic             flush_i;
`ifdef FPU_SCHED_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // Slot k set: the owning core's output is valid during the cycle after
  // k more edges. Slot 1 therefore feeds the capture stage next edge.
  logic [MAX_LAT:1] slot_busy;
  logic [2:0]       slot_unit [1:MAX_LAT];
  logic [TAG_W-1:0] slot_tag  [1:MAX_LAT];

  logic             pend_valid;
  logic [2:0]       pend_unit;
  logic [TAG_W-1:0] pend_tag;

  int               req_lat;
  logic             accept;
  logic [31:0]      core_sel;

  // Ready when the landing slot of this op is free after this edge's shift.
  always_comb begin
    req_lat   = lat_of(req_op);
    req_ready = 1'b0;
    if (!flush_i && req_lat <= MAX_LAT) begin
      req_ready = 1'b1;
      for (int k = 1; k <= MAX_LAT; k++) begin
        if (slot_busy[k] && (k == req_lat + 1)) req_ready = 1'b0;
      end
    end
  end

  assign accept = req_valid && req_ready;

  // Result mux; the reserved opcode has no core and returns zero.
  always_comb begin
    core_sel = '0;
    case (pend_unit)
      U_ADD:   core_sel = add_result;
      U_MUL:   core_sel = mul_result;
      U_DIV:   core_sel = div_result;
      U_FTOI:  core_sel = ftoi_result;
      U_ITOF:  core_sel = itof_result;
      U_SQRT:  core_sel = sqrt_result;
      default: core_sel = '0;
    endcase
  end

  // Operand registers load only on accept and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpu_a             <= '0;
      fpu_b             <= '0;
      fpu_add_operation <= '0;
    end else if (accept) begin
      fpu_a             <= req_a;
      fpu_b             <= req_b;
      fpu_add_operation <= {5'b0, (req_op == 3'd1)};
    end
  end

  // Reservation vector: shift down each edge, insert the accepted op at its latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_busy <= '0;
      busy      <= 1'b0;
      for (int k = 1; k <= MAX_LAT; k++) begin
        slot_unit[k] <= '0;
        slot_tag[k]  <= '0;
      end
    end else if (flush_i) begin
      slot_busy <= '0;
      busy      <= 1'b0;
    end else begin
      for (int k = 1; k < MAX_LAT; k++) begin
        slot_busy[k] <= slot_busy[k+1];
        slot_unit[k] <= slot_unit[k+1];
        slot_tag[k]  <= slot_tag[k+1];
      end
      slot_busy[MAX_LAT] <= 1'b0;
      for (int k = 1; k <= MAX_LAT; k++) begin
        if (accept && (k == req_lat)) begin
          slot_busy[k] <= 1'b1;
          slot_unit[k] <= unit_of(req_op);
          slot_tag[k]  <= req_tag;
        end
      end
      busy <= (|slot_busy) | accept;
    end
  end

  // Capture: slot 1 arms the pending stage, which samples the core output one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_unit  <= '0;
      pend_tag   <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_tag    <= '0;
      res_err    <= 1'b0;
    end else begin
      pend_valid <= slot_busy[1] && !flush_i;
      pend_unit  <= slot_unit[1];
      pend_tag   <= slot_tag[1];
      res_valid  <= pend_valid && !flush_i;
      if (pend_valid && !flush_i) begin
        res_data <= core_sel;
        res_tag  <= pend_tag;
        res_err  <= (pend_unit == U_NONE);
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_scheduler.sv
// tb_fpu_issue_scheduler: directed and random stimulus against a queue-based
// model of result landing times, with behavioural stand-ins for the FPU cores.
module tb_fpu_issue_scheduler;

  localparam int TAG_W    = 5;
  localparam int LAT_ADD  = 4;
  localparam int LAT_MUL  = 3;
  localparam int LAT_DIV  = 12;
  localparam int LAT_FTOI = 2;
  localparam int LAT_ITOF = 2;
  localparam int LAT_SQRT = 12;
  localparam int MAX_LAT  = 12;
  localparam int EW       = 16 + 1 + TAG_W + 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
`ifdef FPU_SCHED_FLUSH_EN
  logic             flush = 1'b0;
`endif
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [2:0]       req_op = '0;
  logic [31:0]      req_a = '0;
  logic [31:0]      req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [31:0]      fpu_a, fpu_b;
  logic [5:0]       fpu_add_operation;
  logic [31:0]      add_result = '0, mul_result = '0, div_result = '0;
  logic [31:0]      ftoi_result = '0, itof_result = '0, sqrt_result = '0;
  logic             res_valid, res_err, busy;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;

  fpu_issue_scheduler #(
    .TAG_W(TAG_W), .LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV),
    .LAT_FTOI(LAT_FTOI), .LAT_ITOF(LAT_ITOF), .LAT_SQRT(LAT_SQRT), .MAX_LAT(MAX_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef FPU_SCHED_FLUSH_EN
    .flush(flush),
`endif
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_add_operation(fpu_add_operation),
    .add_result(add_result), .mul_result(mul_result), .div_result(div_result),
    .ftoi_result(ftoi_result), .itof_result(itof_result), .sqrt_result(sqrt_result),
    .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag),
    .res_err(res_err), .busy(busy)
  );

  // ---------------- clock / edge counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- core stand-ins ----------------
  function automatic logic [31:0] f_add(input logic [31:0] a, b, input logic sub);
    return sub ? (a - b) : (a + b);
  endfunction
  function automatic logic [31:0] f_mul(input logic [31:0] a, b);
    return a * b;
  endfunction
  function automatic logic [31:0] f_div(input logic [31:0] a, b);
    return a ^ {b[15:0], b[31:16]};
  endfunction
  function automatic logic [31:0] f_ftoi(input logic [31:0] a);
    return ~a;
  endfunction
  function automatic logic [31:0] f_itof(input logic [31:0] a);
    return {a[15:0], a[31:16]} + 32'd1;
  endfunction
  function automatic logic [31:0] f_sqrt(input logic [31:0] a);
    return (a >> 1) ^ 32'h5A5A_5A5A;
  endfunction

  // Operand history indexed by edge number; a core of latency L presents
  // f(operands registered at edge n-L) during the cycle after edge n.
  logic [31:0] ha [64];
  logic [31:0] hb [64];
  logic        hs [64];
  function automatic logic [5:0] ago(input int n, input int d);
    return 6'(n - d);
  endfunction
  always @(negedge clk) begin
    ha[6'(cyc)] = fpu_a;
    hb[6'(cyc)] = fpu_b;
    hs[6'(cyc)] = fpu_add_operation[0];
    add_result  = f_add(ha[ago(cyc, LAT_ADD)], hb[ago(cyc, LAT_ADD)], hs[ago(cyc, LAT_ADD)]);
    mul_result  = f_mul(ha[ago(cyc, LAT_MUL)], hb[ago(cyc, LAT_MUL)]);
    div_result  = f_div(ha[ago(cyc, LAT_DIV)], hb[ago(cyc, LAT_DIV)]);
    ftoi_result = f_ftoi(ha[ago(cyc, LAT_FTOI)]);
    itof_result = f_itof(ha[ago(cyc, LAT_ITOF)]);
    sqrt_result = f_sqrt(ha[ago(cyc, LAT_SQRT)]);
  end

  // ---------------- reference model ----------------
  function automatic int lat_of(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: return LAT_ADD;
      3'd2:       return LAT_MUL;
      3'd3:       return LAT_DIV;
      3'd4:       return LAT_FTOI;
      3'd5:       return LAT_ITOF;
      3'd6:       return LAT_SQRT;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [31:0] exp_result(input logic [2:0] op, input logic [31:0] a, b);
    case (op)
      3'd0:    return f_add(a, b, 1'b0);
      3'd1:    return f_add(a, b, 1'b1);
      3'd2:    return f_mul(a, b);
      3'd3:    return f_div(a, b);
      3'd4:    return f_ftoi(a);
      3'd5:    return f_itof(a);
      3'd6:    return f_sqrt(a);
      default: return 32'd0;
    endcase
  endfunction

  // Scoreboard entry: {edge on which res_valid must be seen, err, tag, data}.
  logic [EW-1:0]    exp_q[$];
  logic [31:0]      last_a = '0, last_b = '0, last_data = '0;
  logic             last_sub = 1'b0;
  logic [TAG_W-1:0] last_tag = '0;
  int               checks = 0;
  int               errors = 0;

  function automatic logic slot_taken(input int due);
    foreach (exp_q[i]) if (int'(exp_q[i][EW-1 -: 16]) == due) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Called right after a falling edge; returns right after the next one.
  task automatic drive_cycle(input logic v, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [TAG_W-1:0] tag,
                             input logic fl, output logic acc);
    int            due;
    int            hit;
    logic          mr;
    logic [EW-1:0] e;
    req_valid = v;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
`ifdef FPU_SCHED_FLUSH_EN
    flush = fl;
`endif
    #1;
    due = cyc + 2 + lat_of(op);
    mr  = !fl && (lat_of(op) <= MAX_LAT) && !slot_taken(due);
    check_eq("req_ready", 64'(req_ready), 64'(mr));
    acc = v && mr;
    @(posedge clk);
    if (fl) exp_q.delete();
    if (acc) begin
      exp_q.push_back({16'(due), (op == 3'd7), tag, exp_result(op, a, b)});
      last_a   = a;
      last_b   = b;
      last_sub = (op == 3'd1);
    end
    @(negedge clk);
    hit = -1;
    foreach (exp_q[i]) if (int'(exp_q[i][EW-1 -: 16]) == cyc) hit = i;
    if (hit >= 0) begin
      e = exp_q[hit];
      exp_q.delete(hit);
      check_eq("res_valid", 64'(res_valid), 64'(1));
      check_eq("res_data", 64'(res_data), 64'(e[31:0]));
      check_eq("res_tag", 64'(res_tag), 64'(e[32 +: TAG_W]));
      check_eq("res_err", 64'(res_err), 64'(e[32 + TAG_W]));
      last_data = e[31:0];
      last_tag  = e[32 +: TAG_W];
    end else begin
      check_eq("res_valid_idle", 64'(res_valid), 64'(0));
      check_eq("res_data_hold", 64'(res_data), 64'(last_data));
      check_eq("res_tag_hold", 64'(res_tag), 64'(last_tag));
    end
    check_eq("busy", 64'(busy), 64'(exp_q.size() != 0));
    check_eq("fpu_a", 64'(fpu_a), 64'(last_a));
    check_eq("fpu_b", 64'(fpu_b), 64'(last_b));
    check_eq("fpu_add_op", 64'(fpu_add_operation), 64'({5'b0, last_sub}));
    req_valid = 1'b0;
`ifdef FPU_SCHED_FLUSH_EN
    flush = 1'b0;
`endif
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 3'd0, 32'd0, 32'd0, '0, 1'b0, acc);
  endtask

  // Hold the request until accepted; tries counts attempted edges.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, output int tries);
    logic acc;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 40) begin
      tries++;
      drive_cycle(1'b1, op, a, b, tag, 1'b0, acc);
    end
    if (!acc) check_eq("issue_timeout", 64'(0), 64'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_res_valid"}, 64'(res_valid), 64'(0));
    check_eq({tag, "_res_data"}, 64'(res_data), 64'(0));
    check_eq({tag, "_res_tag"}, 64'(res_tag), 64'(0));
    check_eq({tag, "_res_err"}, 64'(res_err), 64'(0));
    check_eq({tag, "_busy"}, 64'(busy), 64'(0));
    check_eq({tag, "_fpu_a"}, 64'(fpu_a), 64'(0));
    check_eq({tag, "_fpu_b"}, 64'(fpu_b), 64'(0));
    check_eq({tag, "_fpu_add_op"}, 64'(fpu_add_operation), 64'(0));
  endtask

  // Asynchronous assertion mid-cycle, release on a falling edge.
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    exp_q.delete();
    last_a = '0; last_b = '0; last_sub = 1'b0; last_data = '0; last_tag = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int   tries;
    logic acc;
    for (int i = 0; i < 64; i++) begin ha[i] = '0; hb[i] = '0; hs[i] = 1'b0; end
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Plain add: result expected 5 edges after accept.
    issue(3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd3, tries);
    idle(8);

    // Add then mul one cycle later: both would land on the same edge, so mul waits one cycle.
    issue(3'd0, 32'h1111_0000, 32'h0000_2222, 5'd4, tries);
    issue(3'd2, 32'h4040_0000, 32'h4000_0000, 5'd5, tries);
    check_eq("conflict_tries", 64'(tries), 64'(2));
    idle(8);

    // Mul then sub back to back.
    issue(3'd2, 32'h4040_0000, 32'h4000_0000, 5'd1, tries);
    issue(3'd1, 32'h4100_0000, 32'h3F80_0000, 5'd2, tries);
    idle(8);

    // Reserved opcode.
    issue(3'd7, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd9, tries);
    idle(4);

    // Long-latency sqrt followed by a stream of ftoi.
    issue(3'd6, 32'h4110_0000, 32'h0, 5'd10, tries);
    for (int i = 0; i < 12; i++) issue(3'd4, 32'h100 + 32'(i), 32'h0, 5'(11 + i), tries);
    idle(16);

    // Reset with a divide in flight: nothing may come out afterwards.
    issue(3'd3, 32'h4120_0000, 32'h4000_0000, 5'd7, tries);
    idle(3);
    mid_reset();
    idle(16);

`ifdef FPU_SCHED_FLUSH_EN
    // Flush two cycles after a divide, then a fresh add right after.
    issue(3'd3, 32'h4120_0000, 32'h4000_0000, 5'd8, tries);
    idle(1);
    drive_cycle(1'b1, 3'd0, 32'h1, 32'h2, 5'd30, 1'b1, acc);
    issue(3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd12, tries);
    check_eq("post_flush_tries", 64'(tries), 64'(1));
    idle(20);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic fl;
      fl = 1'b0;
`ifdef FPU_SCHED_FLUSH_EN
      fl = ($urandom_range(0, 99) < 3);
`endif
      drive_cycle(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), $urandom, $urandom,
                  TAG_W'($urandom_range(0, 31)), fl, acc);
    end
    idle(20);
    check_eq("drained", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
